// File: rtl/dvp_pattern_tx.sv
// DVP (OV7725-style) RGB565 test-pattern source: counter-driven vsync/href/data
// timing with four selectable patterns, high byte of each pixel first.
module dvp_pattern_tx #(
  parameter logic [10:0] H_DISP   = 11'd640,
  parameter logic [10:0] V_DISP   = 11'd480,
  parameter logic [10:0] H_BLANK  = 11'd144,
  parameter logic [3:0]  VS_LINES = 4'd4,
  parameter logic [5:0]  V_BACK   = 6'd18,
  parameter logic [5:0]  V_FRONT  = 6'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [12:0] LL_M1  = 13'(2 * H_DISP + H_BLANK - 1);
  localparam logic [12:0] H_ACT  = 13'(2 * H_DISP);
  localparam logic [7:0]  BAR_M1 = 8'(H_DISP / 8 - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      state_q, state_d;
  logic [12:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [2:0]  bar_q, bar_d;
  logic [7:0]  bwc_q, bwc_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic [10:0] lines;
  logic [7:0]  x, y;
  logic [15:0] pix;

  function automatic logic [15:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Timing FSM: each state lasts a whole number of line periods.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      S_VSYNC:  lines = {7'd0, VS_LINES};
      S_VBACK:  lines = {5'd0, V_BACK};
      S_ACTIVE: lines = V_DISP;
      S_VFRONT: lines = {5'd0, V_FRONT};
      default:  lines = 11'd1;
    endcase
    if (state_q == S_IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (en) state_d = S_VSYNC;
    end else if (hcnt_q == LL_M1) begin
      hcnt_d = '0;
      if (vcnt_q == lines - 11'd1) begin
        vcnt_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          default:  state_d = en ? S_VSYNC : S_IDLE;
        endcase
      end else begin
        vcnt_d = vcnt_q + 11'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 13'd1;
    end
  end

  // Outputs are derived from the next counter/state values so the registered
  // outputs line up with the state registers in the same cycle.
  always_comb begin
    pat_d = (state_d == S_VSYNC && state_q != S_VSYNC) ? pat_sel : pat_q;
    bar_d = bar_q;
    bwc_d = bwc_q;
    if (hcnt_d == 13'd0) begin
      bar_d = '0;
      bwc_d = '0;
    end else if (!hcnt_d[0]) begin
      if (bwc_q == BAR_M1) begin
        bwc_d = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        bwc_d = bwc_q + 8'd1;
      end
    end
    x = hcnt_d[8:1];
    y = vcnt_d[7:0];
    case (pat_d)
      2'd0:    pix = bar_color(bar_d);
      2'd1:    pix = {x[4:0], x[5:0], x[4:0]};
      2'd2:    pix = {y, x};
      default: pix = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
    endcase
    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE) && (hcnt_d < H_ACT);
    data_d  = href_d ? (hcnt_d[0] ? pix[7:0] : pix[15:8]) : 8'd0;
    done_d  = (state_d == S_VFRONT) && (vcnt_d == {5'd0, V_FRONT} - 11'd1) &&
              (hcnt_d == LL_M1);
    fcnt_d  = fcnt_q + {15'd0, done_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pat_q   <= '0;
      bar_q   <= '0;
      bwc_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pat_q   <= pat_d;
      bar_q   <= bar_d;
      bwc_q   <= bwc_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx in a 16x4 small-frame configuration
// (40-clock lines, 320-clock frames).
module tb_dvp_pattern_tx;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  pat_sel;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  dvp_pattern_tx #(
    .H_DISP(11'd16), .V_DISP(11'd4), .H_BLANK(11'd8),
    .VS_LINES(4'd2), .V_BACK(6'd1), .V_FRONT(6'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int bad;
    pat_sel = 2'd0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cam_vsync || cam_href || cam_data != 8'd0 || frame_done) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: %0d nonzero cycles, required 0", bad);
    end
    n_checks++;
    if (frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
  endtask

  task automatic test_bars_frame();
    int vs_hi, first_low, rises, run, bad_rise, bad_len, fd_cnt, fd_idx, dz;
    logic prev;
    logic [7:0] exp_b;
    int k;
    do_reset();
    pat_sel = 2'd0;
    en = 1'b1;
    vs_hi = 0; first_low = -1; rises = 0; run = 0; bad_rise = 0; bad_len = 0;
    fd_cnt = 0; fd_idx = -1; dz = 0; prev = 1'b0;
    for (int i = 0; i < 320; i++) begin
      step();
      if (i == 0) begin
        n_checks++;
        if (cam_vsync !== 1'b1) begin
          n_fail++;
          $display("FAIL vsync_first_edge: got %b required 1", cam_vsync);
        end
      end
      if (cam_vsync) vs_hi++;
      else if (first_low < 0) first_low = i;
      if (cam_href && !prev) begin
        rises++;
        if (i != 120 + 40 * (rises - 1)) bad_rise++;
        run = 0;
      end
      if (cam_href) run++;
      if (!cam_href && prev && run != 32) bad_len++;
      if (!cam_href && cam_data != 8'd0) dz++;
      if (i >= 120 && i < 152) begin
        k = i - 120;
        exp_b = (k % 2 == 1) ? bars[k / 4][7:0] : bars[k / 4][15:8];
        n_checks++;
        if (cam_data !== exp_b || cam_href !== 1'b1) begin
          n_fail++;
          $display("FAIL bars_byte%0d: got %h href %b required %h href 1", k, cam_data, cam_href, exp_b);
        end
      end
      if (frame_done) begin fd_cnt++; fd_idx = i; end
      if (i == 318) begin
        n_checks++;
        if (frame_cnt !== 16'd0) begin
          n_fail++;
          $display("FAIL frame_cnt_before_done: got %0d required 0", frame_cnt);
        end
      end
      if (i == 319) begin
        n_checks++;
        if (frame_cnt !== 16'd1) begin
          n_fail++;
          $display("FAIL frame_cnt_after_done: got %0d required 1", frame_cnt);
        end
      end
      prev = cam_href;
    end
    n_checks++;
    if (vs_hi !== 80 || first_low !== 80) begin
      n_fail++;
      $display("FAIL vsync_width: high %0d fall %0d required 80/80", vs_hi, first_low);
    end
    n_checks++;
    if (rises !== 4 || bad_rise !== 0) begin
      n_fail++;
      $display("FAIL href_pulses: got %0d (%0d misplaced) required 4 at 120+40n", rises, bad_rise);
    end
    n_checks++;
    if (bad_len !== 0) begin
      n_fail++;
      $display("FAIL href_len: %0d pulses not 32 clocks, required 0", bad_len);
    end
    n_checks++;
    if (dz !== 0) begin
      n_fail++;
      $display("FAIL data_idle_zero: %0d cycles nonzero, required 0", dz);
    end
    n_checks++;
    if (fd_cnt !== 1 || fd_idx !== 319) begin
      n_fail++;
      $display("FAIL frame_done_pos: count %0d at %0d required 1 at 319", fd_cnt, fd_idx);
    end
    step();
    n_checks++;
    if (cam_vsync !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: vsync %b done %b required 1/0", cam_vsync, frame_done);
    end
  endtask

  task automatic test_coord_gradient();
    logic [7:0] exp_b;
    logic [15:0] grad [3] = '{16'h0821, 16'h1042, 16'h79EF};
    int gx [3] = '{1, 2, 15};
    do_reset();
    pat_sel = 2'd2;
    en = 1'b1;
    for (int i = 0; i < 320; i++) begin
      step();
      if (i >= 240 && i < 272) begin
        exp_b = ((i - 240) % 2 == 1) ? 8'((i - 240) / 2) : 8'h03;
        n_checks++;
        if (cam_data !== exp_b) begin
          n_fail++;
          $display("FAIL coord_y3_byte%0d: got %h required %h", i - 240, cam_data, exp_b);
        end
      end
    end
    pat_sel = 2'd1;
    for (int i = 0; i < 320; i++) begin
      step();
      for (int g = 0; g < 3; g++) begin
        if (i == 120 + 2 * gx[g] || i == 121 + 2 * gx[g]) begin
          exp_b = (i % 2 == 1) ? grad[g][7:0] : grad[g][15:8];
          n_checks++;
          if (cam_data !== exp_b) begin
            n_fail++;
            $display("FAIL gradient_x%0d: got %h required %h", gx[g], cam_data, exp_b);
          end
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_pat_change();
    int nz, hc;
    do_reset();
    pat_sel = 2'd0;
    en = 1'b1;
    nz = 0; hc = 0;
    for (int i = 0; i < 640; i++) begin
      step();
      if (i == 130) pat_sel = 2'd3;
      if (i == 240) begin
        n_checks++;
        if (cam_data !== 8'hFF) begin
          n_fail++;
          $display("FAIL patchg_old_x0: got %h required ff", cam_data);
        end
      end
      if (i == 246) begin
        n_checks++;
        if (cam_data !== 8'hFF) begin
          n_fail++;
          $display("FAIL patchg_old_x3: got %h required ff", cam_data);
        end
      end
      if (i == 248) begin
        n_checks++;
        if (cam_data !== 8'h07) begin
          n_fail++;
          $display("FAIL patchg_old_x4: got %h required 07", cam_data);
        end
      end
      if (i >= 320 && cam_href) begin
        hc++;
        if (cam_data != 8'h00) nz++;
      end
    end
    n_checks++;
    if (hc !== 128 || nz !== 0) begin
      n_fail++;
      $display("FAIL patchg_checker: href %0d nonzero %0d required 128/0", hc, nz);
    end
    n_checks++;
    if (frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL patchg_frame_cnt: got %0d required 2", frame_cnt);
    end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    int fd_cnt, fd_idx, vs_late, hc;
    do_reset();
    pat_sel = 2'd0;
    en = 1'b1;
    fd_cnt = 0; fd_idx = -1; vs_late = 0; hc = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (i == 150) en = 1'b0;
      if (frame_done) begin fd_cnt++; fd_idx = i; end
      if (i >= 320 && cam_vsync) vs_late++;
      if (cam_href) hc++;
    end
    n_checks++;
    if (fd_cnt !== 1 || fd_idx !== 319) begin
      n_fail++;
      $display("FAIL endrop_done: count %0d at %0d required 1 at 319", fd_cnt, fd_idx);
    end
    n_checks++;
    if (hc !== 128) begin
      n_fail++;
      $display("FAIL endrop_full_frame: href clocks %0d required 128", hc);
    end
    n_checks++;
    if (vs_late !== 0 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL endrop_idle: vsync clocks %0d cnt %0d required 0/1", vs_late, frame_cnt);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (cam_vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL endrop_restart: vsync %b required 1", cam_vsync);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    pat_sel = 2'd0;
    en = 1'b1;
    for (int i = 0; i < 320 + 210; i++) step();
    n_checks++;
    if (cam_href !== 1'b1 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL areset_pre: href %b cnt %0d required 1/1", cam_href, frame_cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cam_href !== 1'b0 || cam_data !== 8'd0 || cam_vsync !== 1'b0 ||
        frame_cnt !== 16'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_async: href %b data %h vsync %b cnt %0d required all 0",
               cam_href, cam_data, cam_vsync, frame_cnt);
    end
    #1;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (cam_vsync !== 1'b1 || cam_href !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_restart: vsync %b href %b required 1/0", cam_vsync, cam_href);
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    pat_sel = 2'd0;
    test_reset();
    test_bars_frame();
    test_coord_gradient();
    test_pat_change();
    test_en_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
